// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: bus-mapped 8N1 UART transmitter with TX FIFO and level irq.
// Ports: clk, rst (sync, high), ce/we/addr/sel/data_i/data_o bus, txd_o, irq_o.
// Optional irq logic enabled by defining MMIO_UART_TX_IRQ_EN.
module mmio_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        txd_o,
  output logic        irq_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_e;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q;
  state_e        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitcnt_q, bitcnt_d;

  logic [1:0]  a;
  logic        wr_en, push_req, push_ok, pop;
  logic        full, empty, busy, bit_done;
  logic [15:0] div_m1;
  logic [8:0]  cnt_w;
  logic [31:0] ctrl_rd;

  assign a        = addr[3:2];
  assign wr_en    = ce & we;
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push_req = wr_en & (a == 2'd0) & sel[0];
  assign push_ok  = push_req & ~full;
  assign pop      = (state_q == S_IDLE) & ~empty;
  assign cnt_w    = 9'(count_q);

  // Divisor 0 behaves as 1; compare against live register.
  assign div_m1   = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign bit_done = (baud_q >= div_m1);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= data_i[7:0];
  end

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (push_req && full)
      ovf_d = 1'b1;
    else if (wr_en && a == 2'd1 && sel[0] && data_i[3])
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DEFAULT_DIV;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (wr_en && a == 2'd3) begin
        if (sel[0]) div_q[7:0]  <= data_i[7:0];
        if (sel[1]) div_q[15:8] <= data_i[15:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          shift_d = mem[rd_ptr_q];
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          baud_d   = '0;
          bitcnt_d = '0;
          state_d  = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_d   = '0;
          shift_d  = {1'b0, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != S_IDLE);
    txd_o = 1'b1;
    unique case (state_q)
      S_START: txd_o = 1'b0;
      S_DATA:  txd_o = shift_q[0];
      default: txd_o = 1'b1;
    endcase
  end

`ifdef MMIO_UART_TX_IRQ_EN
  logic irq_en_q, irq_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en && a == 2'd2 && sel[0]) irq_en_q <= data_i[0];
      irq_q <= irq_en_q & empty & ~busy;
    end
  end
  assign irq_o   = irq_q;
  assign ctrl_rd = {31'b0, irq_en_q};
`else
  assign irq_o   = 1'b0;
  assign ctrl_rd = '0;
`endif

  always_comb begin
    data_o = '0;
    if (ce && !we) begin
      unique case (a)
        2'd0: data_o = '0;
        2'd1: data_o = {16'b0, cnt_w[7:0], 4'b0,
                        ovf_q, empty, full, busy};
        2'd2: data_o = ctrl_rd;
        2'd3: data_o = {16'b0, div_q};
        default: data_o = '0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], sel[3:2],
                         data_i[31:16], cnt_w[8]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: table-driven register checks plus a serial-line
// scoreboard that decodes txd frames against queued expected bytes.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0, we = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        txd, irq;

`ifdef MMIO_UART_TX_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we),
    .addr(addr), .sel(sel), .data_i(wdata),
    .data_o(rdata), .txd_o(txd), .irq_o(irq)
  );

  int checks = 0;
  int errors = 0;
  byte unsigned exp_q[$];
  int mon_div = 434;
  bit mon_en = 1'b1;
  bit mon_busy = 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] ra, input logic [3:0] s,
                           input logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = {28'b0, ra, 2'b0};
    sel = s; wdata = d;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    ce = 1'b0; we = 1'b0; sel = '0;
  endtask

  task automatic bus_read(input logic [1:0] ra, output logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = {28'b0, ra, 2'b0}; sel = '0;
    #1 d = rdata;
  endtask

  task automatic wait_drain(input string nm);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_busy) begin
        done = 1'b1;
        break;
      end
    end
    check(nm, {31'b0, done}, 32'd1);
  endtask

  // Serial monitor: sample each bit near its middle.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        byte unsigned b;
        int d;
        d = mon_div;
        mon_busy = 1'b1;
        repeat (d / 2) @(negedge clk);
        check("start_bit", {31'b0, txd}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (d) @(negedge clk);
          b[i] = txd;
        end
        repeat (d) @(negedge clk);
        check("stop_bit", {31'b0, txd}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame got %h exp none", b);
        end else begin
          check("frame", {24'b0, b}, {24'b0, exp_q.pop_front()});
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          c;
    bit          w;
    logic [1:0]  a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tv[16];
  logic [31:0] r;
  logic [9:0]  frm;
  bit          seen_low;

  initial begin
    tv[0]  = '{1'b1, 1'b0, 2'd1, 4'h0, 32'h0, 32'h4};
    tv[1]  = '{1'b0, 1'b0, 2'd3, 4'h0, 32'h0, 32'h0};
    tv[2]  = '{1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0};
    tv[3]  = '{1'b1, 1'b0, 2'd3, 4'h0, 32'h0, 32'h1B2};
    tv[4]  = '{1'b1, 1'b1, 2'd3, 4'h1, 32'h1203, 32'h0};
    tv[5]  = '{1'b1, 1'b0, 2'd3, 4'h0, 32'h0, 32'h103};
    tv[6]  = '{1'b1, 1'b1, 2'd3, 4'h0, 32'hFFFF, 32'h0};
    tv[7]  = '{1'b1, 1'b0, 2'd3, 4'h0, 32'h0, 32'h103};
    tv[8]  = '{1'b1, 1'b1, 2'd3, 4'h2, 32'h0500, 32'h0};
    tv[9]  = '{1'b1, 1'b0, 2'd3, 4'h0, 32'h0, 32'h503};
    tv[10] = '{1'b1, 1'b1, 2'd2, 4'hF, 32'hFFFF_FFFF, 32'h0};
    tv[11] = '{1'b1, 1'b0, 2'd2, 4'h0, 32'h0, {31'b0, IRQ}};
    tv[12] = '{1'b1, 1'b1, 2'd2, 4'h1, 32'h0, 32'h0};
    tv[13] = '{1'b1, 1'b0, 2'd2, 4'h0, 32'h0, 32'h0};
    tv[14] = '{1'b1, 1'b1, 2'd3, 4'h3, 32'h4, 32'h0};
    tv[15] = '{1'b1, 1'b0, 2'd3, 4'h0, 32'h0, 32'h4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; ce = 1'b1; we = 1'b0; addr = 32'h4;
    #1;
    check("rst_status", rdata, 32'h4);
    check("rst_txd", {31'b0, txd}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    ce = 1'b0;
    #1 check("ce0_read", rdata, 32'h0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ce = tv[i].c; we = tv[i].w;
      addr = {28'b0, tv[i].a, 2'b0};
      sel = tv[i].s; wdata = tv[i].d;
      #1 check($sformatf("vec%0d", i), rdata, tv[i].exp);
    end
    bus_idle();

    // DIVISOR=4, one 0x55 frame with exact bit timing.
    mon_div = 4;
    exp_q.push_back(8'h55);
    bus_write(2'd0, 4'h1, 32'h55);
    bus_read(2'd1, r);
    check("div4_status_n", r, 32'h100);
    check("div4_txd_n", {31'b0, txd}, 32'd1);
    frm = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("div4_txd%0d", k), {31'b0, txd},
            {31'b0, frm[k / 4]});
      check($sformatf("div4_busy%0d", k), {31'b0, rdata[0]}, 32'd1);
    end
    @(negedge clk);
    #1 check("div4_done", rdata, 32'h4);
    ce = 1'b0;
    wait_drain("div4_drain");

    // DIVISOR=2, 18 back-to-back pushes overflow a 16-deep FIFO.
    bus_write(2'd3, 4'h3, 32'h2);
    bus_idle();
    mon_div = 2;
    for (int i = 0; i < 18; i++) begin
      if (i < 17) exp_q.push_back(8'(i));
      bus_write(2'd0, 4'h1, i);
    end
    bus_read(2'd1, r);
    check("ovf_status", r, 32'h100B);
    bus_write(2'd1, 4'h1, 32'h8);
    bus_read(2'd1, r);
    check("ovf_clear", r, 32'h1003);
    bus_idle();
    wait_drain("div2_drain");
    bus_read(2'd1, r);
    check("div2_idle", r, 32'h4);

    // Interrupt timing with DIVISOR=1.
    bus_write(2'd3, 4'h3, 32'h1);
    bus_write(2'd2, 4'h1, 32'h1);
    bus_idle();
    mon_div = 1;
    repeat (2) @(negedge clk);
    check("irq_pre", {31'b0, irq}, {31'b0, IRQ});
    exp_q.push_back(8'h9A);
    bus_write(2'd0, 4'h1, 32'h9A);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      ce = 1'b0; we = 1'b0;
      #1 check($sformatf("irq%0d", k), {31'b0, irq},
               {31'b0, IRQ && (k == 0 || k >= 12)});
    end
    wait_drain("irq_drain");
    bus_write(2'd2, 4'h1, 32'h0);
    bus_idle();

    // Reset in the middle of DATA bit 3.
    mon_en = 1'b0;
    bus_write(2'd3, 4'h3, 32'h4);
    bus_write(2'd0, 4'h1, 32'hA5);
    bus_write(2'd0, 4'h1, 32'h3C);
    repeat (18) begin
      @(negedge clk);
      ce = 1'b0; we = 1'b0;
    end
    #1 check("pre_rst_bit3", {31'b0, txd}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ce = 1'b1; we = 1'b0; addr = 32'h4;
    #1;
    check("rst_mid_txd", {31'b0, txd}, 32'd1);
    check("rst_mid_status", rdata, 32'h4);
    seen_low = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1) seen_low = 1'b1;
    end
    check("rst_no_frame", {31'b0, seen_low}, 32'd0);
    bus_read(2'd3, r);
    check("rst_div", r, 32'h1B2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
